data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Data-memory target answering the mem_read/mem_write strobes that the processor
//   control unit issues during its MEM state. It latches address and data, waits a
//   programmable number of cycles, then commits the write or returns read data.
//   Result is a write_ack or rdata_valid pulse. Illegal requests raise err.
//   Sits between the control unit / datapath and the data store of the crypto core.
// PARAMETERS
//   ADDR_W   8    address width
//   DATA_W   8    data word width
//   DEPTH    256  implemented words, 1..2**ADDR_W; addr >= DEPTH is out of range
//   LATENCY  2    wait cycles between accept and response, 0..15
// PORTS
//   clk          in   1       rising-edge clock
//   reset_n      in   1       asynchronous, active-low reset
//   mem_read     in   1       read request strobe, sampled every edge
//   mem_write    in   1       write request strobe, sampled every edge
//   addr         in   ADDR_W  request address, sampled with strobe
//   wdata        in   DATA_W  write data, sampled with mem_write
//   rdata        out  DATA_W  read data; holds last read result
//   rdata_valid  out  1       1-cycle pulse: rdata carries new read result
//   write_ack    out  1       1-cycle pulse: write committed to array
//   busy         out  1       request in flight (WAIT or RESP)
//   err          out  1       1-cycle pulse: request rejected
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE, counter=0, all outputs 0, request
//     latches cleared. Array contents NOT reset. In-flight request aborted;
//     pending write discarded (no array update, no ack).
//   FSM: IDLE -> WAIT -> RESP -> IDLE. All outputs registered.
//   IDLE: strobe sampled high at edge ending cycle T:
//     - exactly one of mem_read/mem_write, addr<DEPTH: latch addr, wdata, op.
//       Next state WAIT with counter=LATENCY, or RESP directly if LATENCY=0.
//     - mem_read and mem_write both high: reject, err=1 in T+1, stay IDLE.
//     - addr>=DEPTH: reject, err=1 in T+1, stay IDLE, array untouched.
//   WAIT: counter decrements each cycle. Move to RESP on the edge where counter=1.
//     Occupies exactly LATENCY cycles (T+1..T+LATENCY).
//   Edge entering RESP:
//     - write: array[addr] <= wdata.
//     - read: rdata <= array[addr].
//   RESP: exactly one cycle, T+1+LATENCY.
//     - write_ack=1 for a write, or rdata_valid=1 for a read.
//     - Then IDLE. Latency = LATENCY+1 cycles from strobe cycle to response cycle.
//   busy: 1 for cycles T+1..T+1+LATENCY inclusive, 0 otherwise.
//   Overrun: any strobe sampled while not IDLE (incl. RESP cycle):
//     - dropped, err=1 next cycle.
//     - in-flight request completes unaffected.
//     - next request accepted only from IDLE (first edge after RESP).
//   err, write_ack, rdata_valid never held >1 cycle per event; err may coincide
//     with write_ack/rdata_valid (overrun during RESP).
//   rdata changes only on read completion; unchanged by writes, errors, rejects.
//   Read-after-write to same address issued after write_ack returns new data.
//   Counter width 4 bits; LATENCY outside 0..15 is illegal (elaboration check).
// TESTING
//   1. reset_n=0 mid-cycle -> all outputs 0 immediately; release -> IDLE, busy=0.
//   2. LATENCY=2, write 0xA5 @0x10 in cycle T:
//      busy T+1..T+3, write_ack only T+3.
//      Then read 0x10 -> rdata_valid at +3 cycles, rdata=0xA5.
//   3. mem_read=mem_write=1 @0x20 -> err=1 next cycle, busy stays 0.
//      Follow-up read 0x20 returns prior contents.
//   4. Read 0x10 at T, write 0x11 at T+1 -> err at T+2.
//      Read completes at T+3 (0xA5). 0x11 never written.
//   5. DEPTH=200, read 0xF0 -> err next cycle, no rdata_valid, rdata unchanged.
//      LATENCY=0 write 0x3C @0x05 -> write_ack at T+1.
//   6. Write 0x77 @0x10 (old 0xA5), reset_n=0 during WAIT:
//      busy drops at once, no write_ack; later read 0x10 returns 0xA5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory target for the control unit's MEM-state strobes: accepts one request,
// waits LATENCY cycles, then commits the write or returns the read word.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              write_ack,
    output logic              busy,
    output logic              err
);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be within 0..15");
        end
    endgenerate

    localparam logic [3:0]      LAT     = 4'(LATENCY);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_strobe, w_in_range, w_accept, w_enter_resp, w_op_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_busy_nxt, w_ack_nxt, w_valid_nxt, w_err_nxt;

    assign w_strobe   = mem_read | mem_write;
    assign w_in_range = ({1'b0, addr} < DEPTH_L);
    assign w_accept   = (r_state == S_IDLE) && (mem_read ^ mem_write) && w_in_range;

    // With LATENCY=0 the commit happens on the accepting edge, so use the live inputs.
    assign w_op_wr = (r_state == S_IDLE) ? mem_write : r_op_wr;
    assign w_addr  = (r_state == S_IDLE) ? addr      : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? wdata     : r_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_op_wr     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            write_ack   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            rdata_valid <= w_valid_nxt;
            write_ack   <= w_ack_nxt;
            busy        <= w_busy_nxt;
            err         <= w_err_nxt;
            if (w_accept) begin
                r_op_wr <= mem_write;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (w_valid_nxt) begin
                rdata <= r_mem[w_addr];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = LAT;
                    w_state_nxt = (LAT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_enter_resp = (w_state_nxt == S_RESP);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_ack_nxt    = w_enter_resp && w_op_wr;
        w_valid_nxt  = w_enter_resp && !w_op_wr;
        w_err_nxt    = w_strobe && ((r_state != S_IDLE) || (mem_read && mem_write) || !w_in_range);
    end

    // Array has no reset; an aborted request never reaches the enter-RESP edge.
    always_ff @(posedge clk) begin
        if (w_ack_nxt) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a cycle-numbered transaction model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       a_rd, a_wr, a_valid, a_ack, a_busy, a_err;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_rd, b_wr, b_valid, b_ack, b_busy, b_err;
    logic [7:0] b_addr, b_wdata, b_rdata;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .mem_read(a_rd), .mem_write(a_wr),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .rdata_valid(a_valid),
        .write_ack(a_ack), .busy(a_busy), .err(a_err));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .mem_read(b_rd), .mem_write(b_wr),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .rdata_valid(b_valid),
        .write_ack(b_ack), .busy(b_busy), .err(b_err));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       e_err;
        logic       e_busy;
        logic       e_ack;
        logic       e_valid;
        logic [7:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] ad,
                                input logic [7:0] wd, input logic e_err, input logic e_busy,
                                input logic e_ack, input logic e_valid, input logic [7:0] e_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = ad; v.wdata = wd;
        v.e_err = e_err; v.e_busy = e_busy; v.e_ack = e_ack; v.e_valid = e_valid;
        v.e_rdata = e_rdata;
        return v;
    endfunction

    // One request on DUT A (LATENCY=2), issued in the cycle of the current negedge.
    task automatic run_vec(input vec_t v, input string nm);
        a_rd = v.rd; a_wr = v.wr; a_addr = v.addr; a_wdata = v.wdata;
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
        chk({nm, " err T+1"}, a_err, v.e_err);
        chk({nm, " busy T+1"}, a_busy, v.e_busy);
        chk({nm, " no pulse T+1"}, {a_ack, a_valid}, 0);
        @(negedge clk);
        chk({nm, " busy T+2"}, a_busy, v.e_busy);
        chk({nm, " no pulse T+2"}, {a_ack, a_valid, a_err}, 0);
        @(negedge clk);
        chk({nm, " ack T+3"}, a_ack, v.e_ack);
        chk({nm, " valid T+3"}, a_valid, v.e_valid);
        chk({nm, " rdata T+3"}, a_rdata, v.e_rdata);
        chk({nm, " busy T+3"}, a_busy, v.e_busy);
        @(negedge clk);
        chk({nm, " quiet T+4"}, {a_busy, a_ack, a_valid, a_err}, 0);
    endtask

    // One request on DUT B (LATENCY=0): response lands one cycle after the strobe.
    task automatic b_txn(input string nm, input logic rd, input logic wr, input logic [7:0] ad,
                         input logic [7:0] wd, input logic e_err, input logic e_ack,
                         input logic e_valid, input logic [7:0] e_rdata);
        b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd;
        @(negedge clk);
        b_rd = 1'b0; b_wr = 1'b0;
        chk({nm, " err"}, b_err, e_err);
        chk({nm, " ack"}, b_ack, e_ack);
        chk({nm, " valid"}, b_valid, e_valid);
        chk({nm, " busy"}, b_busy, e_ack | e_valid);
        chk({nm, " rdata"}, b_rdata, e_rdata);
        @(negedge clk);
        chk({nm, " quiet"}, {b_err, b_ack, b_valid, b_busy}, 0);
    endtask

    vec_t tbl[8];

    // Reference model state for the random run (cycle numbers, not FSM states).
    int         acc_c, resp_c, err_c;
    logic       p_wr;
    logic [7:0] p_addr, p_data, m_rdata;
    logic [7:0] mmem [256];

    initial begin
        reset_n = 1'b1;
        a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;

        // Reset asserted mid-cycle: outputs must clear at once.
        #2 reset_n = 1'b0;
        #1;
        chk("reset outputs A", {a_rdata, a_valid, a_ack, a_busy, a_err}, 0);
        chk("reset outputs B", {b_rdata, b_valid, b_ack, b_busy, b_err}, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("after release busy", {a_busy, b_busy}, 0);

        tbl[0] = mk(0, 1, 8'h10, 8'hA5, 0, 1, 1, 0, 8'h00);
        tbl[1] = mk(1, 0, 8'h10, 8'h00, 0, 1, 0, 1, 8'hA5);
        tbl[2] = mk(0, 1, 8'h20, 8'h5A, 0, 1, 1, 0, 8'hA5);
        tbl[3] = mk(1, 1, 8'h20, 8'hFF, 1, 0, 0, 0, 8'hA5);
        tbl[4] = mk(1, 0, 8'h20, 8'h00, 0, 1, 0, 1, 8'h5A);
        tbl[5] = mk(0, 1, 8'h11, 8'h44, 0, 1, 1, 0, 8'h5A);
        tbl[6] = mk(1, 0, 8'h10, 8'h00, 0, 1, 0, 1, 8'hA5);
        tbl[7] = mk(1, 0, 8'h11, 8'h00, 0, 1, 0, 1, 8'h44);
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Read 0x10 then a write to 0x11 one cycle later while busy.
        a_rd = 1; a_addr = 8'h10;
        @(negedge clk);
        a_rd = 0; a_wr = 1; a_addr = 8'h11; a_wdata = 8'h99;
        chk("ovr busy T+1", a_busy, 1);
        chk("ovr err T+1", a_err, 0);
        @(negedge clk);
        a_wr = 0;
        chk("ovr err T+2", a_err, 1);
        chk("ovr busy T+2", a_busy, 1);
        @(negedge clk);
        chk("ovr valid T+3", a_valid, 1);
        chk("ovr rdata T+3", a_rdata, 8'hA5);
        chk("ovr err T+3", a_err, 0);
        @(negedge clk);
        chk("ovr quiet T+4", {a_busy, a_valid, a_err}, 0);
        run_vec(mk(1, 0, 8'h11, 8'h00, 0, 1, 0, 1, 8'h44), "ovr dropped write");

        // Strobe during the RESP cycle is dropped with err the cycle after.
        a_wr = 1; a_addr = 8'h22; a_wdata = 8'h66;
        @(negedge clk);
        a_wr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("resp ovr ack", a_ack, 1);
        a_rd = 1; a_addr = 8'h22;
        @(negedge clk);
        a_rd = 0;
        chk("resp ovr err", a_err, 1);
        chk("resp ovr quiet", {a_busy, a_valid, a_ack}, 0);
        run_vec(mk(1, 0, 8'h22, 8'h00, 0, 1, 0, 1, 8'h66), "resp ovr readback");

        // Reset during WAIT aborts the pending write.
        a_wr = 1; a_addr = 8'h10; a_wdata = 8'h77;
        @(negedge clk);
        a_wr = 0;
        chk("abort busy before", a_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort outputs", {a_rdata, a_valid, a_ack, a_busy, a_err}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort no ack %0d", i), {a_ack, a_busy}, 0);
        end
        run_vec(mk(1, 0, 8'h10, 8'h00, 0, 1, 0, 1, 8'hA5), "abort readback");

        // DUT B: DEPTH=200, LATENCY=0.
        b_txn("B wr 05", 0, 1, 8'h05, 8'h3C, 0, 1, 0, 8'h00);
        b_txn("B rd 05", 1, 0, 8'h05, 8'h00, 0, 0, 1, 8'h3C);
        b_txn("B rd F0", 1, 0, 8'hF0, 8'h00, 1, 0, 0, 8'h3C);
        b_txn("B wr C7", 0, 1, 8'hC7, 8'h81, 0, 1, 0, 8'h3C);
        b_txn("B wr C8", 0, 1, 8'hC8, 8'hEE, 1, 0, 0, 8'h3C);
        b_txn("B rd C7", 1, 0, 8'hC7, 8'h00, 0, 0, 1, 8'h81);
        b_txn("B rd C8", 1, 0, 8'hC8, 8'h00, 1, 0, 0, 8'h81);
        b_wr = 1; b_addr = 8'h06; b_wdata = 8'h12;
        @(negedge clk);
        b_wr = 0; b_rd = 1; b_addr = 8'h05;
        chk("B resp ovr ack", b_ack, 1);
        @(negedge clk);
        b_rd = 0;
        chk("B resp ovr err", b_err, 1);
        chk("B resp ovr quiet", {b_valid, b_busy, b_ack}, 0);
        @(negedge clk);
        b_txn("B rd 06", 1, 0, 8'h06, 8'h00, 0, 0, 1, 8'h12);

        // Randomized run on DUT A against the transaction model.
        acc_c = -10; resp_c = -10; err_c = -10;
        p_wr = 0; p_addr = 0; p_data = 0;
        m_rdata = 8'hA5;
        for (int c = 0; c < 600; c++) begin
            logic       exp_busy, rd, wr;
            logic [7:0] ad, wd;
            int         r;
            exp_busy = (c > acc_c) && (c <= resp_c);
            if (c == resp_c) begin
                if (p_wr) mmem[p_addr] = p_data;
                else      m_rdata = mmem[p_addr];
            end
            chk($sformatf("rnd busy c%0d", c), a_busy, exp_busy);
            chk($sformatf("rnd ack c%0d", c), a_ack, (c == resp_c) && p_wr);
            chk($sformatf("rnd valid c%0d", c), a_valid, (c == resp_c) && !p_wr);
            chk($sformatf("rnd err c%0d", c), a_err, c == err_c);
            chk($sformatf("rnd rdata c%0d", c), a_rdata, m_rdata);

            rd = 0; wr = 0;
            ad = 8'($urandom_range(0, 15));
            wd = 8'($urandom);
            if (c < 64) begin
                if (c % 4 == 0) begin
                    wr = 1;
                    ad = 8'(c / 4);
                end
            end else if (c < 590) begin
                r = $urandom_range(0, 9);
                rd = (r <= 2) || (r == 6);
                wr = (r >= 3 && r <= 6);
            end
            a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
            if (rd || wr) begin
                if (exp_busy || (rd && wr)) begin
                    err_c = c + 1;
                end else begin
                    acc_c  = c;
                    resp_c = c + 3;
                    p_wr   = wr;
                    p_addr = ad;
                    p_data = wd;
                end
            end
            @(negedge clk);
        end
        a_rd = 0; a_wr = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
